// File: rtl/btn_pkg.sv
// Shared constants for the pushbutton conditioner: button indices, default widths and masks.
// Optional auto-repeat is enabled by defining BTN_AUTOREPEAT_EN.
package btn_pkg;

   localparam int unsigned NUM_BTN_DEF = 6;

   localparam int unsigned BTN_UP     = 0;
   localparam int unsigned BTN_DOWN   = 1;
   localparam int unsigned BTN_LEFT   = 2;
   localparam int unsigned BTN_RIGHT  = 3;
   localparam int unsigned BTN_ATTACK = 4;
   localparam int unsigned BTN_BLOCK  = 5;

   // Directions only are eligible for auto-repeat by default.
   localparam logic [NUM_BTN_DEF-1:0] REPEAT_MASK_DEF = 6'b001111;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/btn_debounce_cell.sv
// One button: 2-flop synchroniser, debounce counter, press pulse, optional repeat timer.
// Repeat timer is only built when BTN_AUTOREPEAT_EN is defined.
module btn_debounce_cell
   import btn_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 4
`ifdef BTN_AUTOREPEAT_EN
   , parameter int unsigned REPEAT_DELAY  = 10
   , parameter int unsigned REPEAT_PERIOD = 5
   , parameter bit          REPEAT_EN     = 1'b1
`endif
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_raw,
   output logic o_level,
   output logic o_press,
   output logic o_press_d_c
);

   localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

   logic          r_sync1;
   logic          r_sync2;
   logic          r_level;
   logic          r_press;
   logic [CW-1:0] r_cnt;

   logic w_diff;
   logic w_toggle;
   logic w_rise;
   logic w_rpt_fire;
   logic w_press_d;

   // Accept a change on the DEBOUNCE_CYCLES-th consecutive differing sample.
   always_comb begin
      w_diff    = r_sync2 ^ r_level;
      w_toggle  = w_diff && (r_cnt == CW'(DEBOUNCE_CYCLES - 1));
      w_rise    = w_toggle && !r_level;
      w_press_d = w_rise || w_rpt_fire;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_cnt   <= '0;
         r_level <= 1'b0;
         r_press <= 1'b0;
      end else begin
         r_sync1 <= i_raw;
         r_sync2 <= r_sync1;
         if (!w_diff || w_toggle) begin
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + CW'(1);
         end
         if (w_toggle) begin
            r_level <= ~r_level;
         end
         r_press <= w_press_d;
      end
   end

`ifdef BTN_AUTOREPEAT_EN
   localparam int unsigned RW = $clog2(max_u(REPEAT_DELAY, REPEAT_PERIOD) + 1);

   logic [RW-1:0] r_rpt_cnt;
   logic          r_rpt_first;
   logic [RW-1:0] w_rpt_limit;

   // Timer counts from the accepted press; the release edge itself never fires.
   always_comb begin
      w_rpt_limit = r_rpt_first ? RW'(REPEAT_DELAY) : RW'(REPEAT_PERIOD);
      w_rpt_fire  = REPEAT_EN && r_level && !w_toggle &&
                    ((r_rpt_cnt + RW'(1)) == w_rpt_limit);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_rpt_cnt   <= '0;
         r_rpt_first <= 1'b0;
      end else if (w_rise || !r_level) begin
         r_rpt_cnt   <= '0;
         r_rpt_first <= 1'b1;
      end else if (w_rpt_fire) begin
         r_rpt_cnt   <= '0;
         r_rpt_first <= 1'b0;
      end else begin
         r_rpt_cnt   <= r_rpt_cnt + RW'(1);
      end
   end
`else
   assign w_rpt_fire = 1'b0;
`endif

   assign o_level     = r_level;
   assign o_press     = r_press;
   assign o_press_d_c = w_press_d;

endmodule

// File: rtl/button_conditioner.sv
// Debounces the raw pushbuttons into clean levels and single-cycle press pulses.
// Define BTN_AUTOREPEAT_EN to regenerate press pulses while masked buttons are held.
module button_conditioner
   import btn_pkg::*;
#(
   parameter int unsigned         NUM_BTN         = NUM_BTN_DEF,
   parameter int unsigned         DEBOUNCE_CYCLES = 4,
   parameter int unsigned         REPEAT_DELAY    = 10,
   parameter int unsigned         REPEAT_PERIOD   = 5,
   parameter logic [NUM_BTN-1:0]  REPEAT_MASK     = NUM_BTN'(REPEAT_MASK_DEF)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_BTN-1:0] btn_raw,
   output logic [NUM_BTN-1:0] btn_level,
   output logic [NUM_BTN-1:0] btn_press,
   output logic               any_press
);

   // Reject configurations the cells cannot implement.
   if (NUM_BTN < 1 || DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1 ||
       $bits(REPEAT_MASK) != NUM_BTN) begin : g_bad_cfg
      $error("button_conditioner: illegal parameter configuration");
   end

   logic [NUM_BTN-1:0] w_press_d;
   logic               r_any_press;

   for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
      btn_debounce_cell #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`ifdef BTN_AUTOREPEAT_EN
         , .REPEAT_DELAY  (REPEAT_DELAY)
         , .REPEAT_PERIOD (REPEAT_PERIOD)
         , .REPEAT_EN     (REPEAT_MASK[gi])
`endif
      ) u_cell (
         .clk         (clk),
         .rst_n       (rst_n),
         .i_raw       (btn_raw[gi]),
         .o_level     (btn_level[gi]),
         .o_press     (btn_press[gi]),
         .o_press_d_c (w_press_d[gi])
      );
   end

   // Registered from the cells' next-press terms so it lines up with btn_press.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_any_press <= 1'b0;
      end else begin
         r_any_press <= |w_press_d;
      end
   end

   assign any_press = r_any_press;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner (default DEBOUNCE_CYCLES=4, delay 10, period 5).
module tb_button_conditioner;

`ifdef BTN_AUTOREPEAT_EN
   localparam bit AR = 1'b1;
`else
   localparam bit AR = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n;
   logic [5:0] btn_raw;
   logic [5:0] btn_level;
   logic [5:0] btn_press;
   logic       any_press;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   button_conditioner dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .btn_raw   (btn_raw),
      .btn_level (btn_level),
      .btn_press (btn_press),
      .any_press (any_press)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [5:0] got, input logic [5:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s observed=%b expected=%b", tag, got, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [5:0] lvl, input logic [5:0] prs);
      chk({tag, ".level"}, btn_level, lvl);
      chk({tag, ".press"}, btn_press, prs);
      chk({tag, ".any"}, {5'b0, any_press}, {5'b0, |prs});
   endtask

   // s = edges since raw rose, p = accept edge, fall = release-accept edge
   function automatic logic exp_pulse(input int s, input int p, input int fall, input bit rpt);
      logic r;
      r = (s == p);
      if (AR && rpt && s >= p + 10 && s < fall && ((s - p - 10) % 5) == 0) r = 1'b1;
      return r;
   endfunction

   initial begin
      logic [0:9] bseq;
      logic [5:0] lvl;
      logic [5:0] prs;
      bseq = 10'b1011011111;

      // reset with all buttons held
      rst_n   = 1'b0;
      btn_raw = 6'b111111;
      repeat (3) step();
      chk_all("reset", 6'b0, 6'b0);
      rst_n = 1'b1;
      for (int s = 1; s <= 7; s++) begin
         step();
         lvl = (s >= 6) ? 6'b111111 : 6'b0;
         prs = (s == 6) ? 6'b111111 : 6'b0;
         chk_all($sformatf("rst_rel_%0d", s), lvl, prs);
      end
      btn_raw = 6'b0;
      for (int s = 1; s <= 8; s++) begin
         step();
         lvl = (s < 6) ? 6'b111111 : 6'b0;
         chk_all($sformatf("rel_all_%0d", s), lvl, 6'b0);
      end

      // clean press on up, held 20 cycles then released
      btn_raw[0] = 1'b1;
      for (int s = 1; s <= 28; s++) begin
         if (s == 21) btn_raw[0] = 1'b0;
         step();
         lvl = (s >= 6 && s < 26) ? 6'b000001 : 6'b0;
         prs = {5'b0, exp_pulse(s, 6, 26, 1'b1)};
         chk_all($sformatf("up_%0d", s), lvl, prs);
      end

      // bouncing attack button
      for (int i = 0; i < 16; i++) begin
         if (i < 10) btn_raw[4] = bseq[i];
         step();
         lvl = (i + 1 >= 11) ? 6'b010000 : 6'b0;
         prs = (i + 1 == 11) ? 6'b010000 : 6'b0;
         chk_all($sformatf("bounce_%0d", i + 1), lvl, prs);
      end
      btn_raw[4] = 1'b0;
      repeat (8) step();
      chk_all("bounce_rel", 6'b0, 6'b0);

      // 3-cycle glitch on block
      btn_raw[5] = 1'b1;
      for (int s = 1; s <= 12; s++) begin
         if (s == 4) btn_raw[5] = 1'b0;
         step();
         chk_all($sformatf("glitch_%0d", s), 6'b0, 6'b0);
      end

      // simultaneous left + attack
      btn_raw = 6'b010100;
      for (int s = 1; s <= 8; s++) begin
         step();
         lvl = (s >= 6) ? 6'b010100 : 6'b0;
         prs = (s == 6) ? 6'b010100 : 6'b0;
         chk_all($sformatf("simul_%0d", s), lvl, prs);
      end
      btn_raw = 6'b0;
      for (int s = 1; s <= 8; s++) begin
         step();
         lvl = (s < 6) ? 6'b010100 : 6'b0;
         chk_all($sformatf("simul_rel_%0d", s), lvl, 6'b0);
      end

      // reset mid-debounce of right, released during reset
      btn_raw[3] = 1'b1;
      repeat (3) step();
      chk_all("rstmid_pre", 6'b0, 6'b0);
      rst_n      = 1'b0;
      btn_raw[3] = 1'b0;
      repeat (2) step();
      chk_all("rstmid_in", 6'b0, 6'b0);
      rst_n = 1'b1;
      for (int s = 1; s <= 10; s++) begin
         step();
         chk_all($sformatf("rstmid_post_%0d", s), 6'b0, 6'b0);
      end

      // right held through reset, then held long (repeat eligible)
      btn_raw[3] = 1'b1;
      repeat (3) step();
      rst_n = 1'b0;
      repeat (2) step();
      chk_all("hold_rst", 6'b0, 6'b0);
      rst_n = 1'b1;
      for (int s = 1; s <= 54; s++) begin
         if (s == 47) btn_raw[3] = 1'b0;
         step();
         lvl = (s >= 6 && s < 52) ? 6'b001000 : 6'b0;
         prs = {2'b0, exp_pulse(s, 6, 52, 1'b1), 3'b0};
         chk_all($sformatf("hold_right_%0d", s), lvl, prs);
      end

      // attack held long: not repeat eligible
      btn_raw[4] = 1'b1;
      for (int s = 1; s <= 38; s++) begin
         if (s == 31) btn_raw[4] = 1'b0;
         step();
         lvl = (s >= 6 && s < 36) ? 6'b010000 : 6'b0;
         prs = {1'b0, exp_pulse(s, 6, 36, 1'b0), 4'b0};
         chk_all($sformatf("hold_attack_%0d", s), lvl, prs);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
